// File: rtl/modmul_datapath.sv
// Modular multiplier datapath: computes A*B mod N with one MSB-first
// shift-add step per en_multiply strobe and one conditional-subtract
// reduction per en_modulo strobe. Sequencing belongs to an external controller.
module modmul_datapath #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             initialize,
    input  logic             en_multiply,
    input  logic             en_modulo,
    input  logic             done,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [WIDTH-1:0] modulus,
    output logic             is_multiplication_done,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             error
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int RW = WIDTH + 2;
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    // Operands are illegal when the modulus is zero or either operand is not reduced.
    function automatic logic operands_illegal(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] n
    );
        return (n == {WIDTH{1'b0}}) || (a >= n) || (b >= n);
    endfunction

    // One MSB-first shift-add step: 2R + (bit ? A : 0); stays below 3N when R < N and A < N.
    function automatic logic [RW-1:0] shift_add(
        input logic [RW-1:0]    acc,
        input logic [WIDTH-1:0] a,
        input logic             mul_bit
    );
        logic [RW-1:0] addend;
        addend = mul_bit ? {2'b00, a} : {RW{1'b0}};
        return {acc[RW-2:0], 1'b0} + addend;
    endfunction

    // Single-cycle reduction of an accumulator known to be below 3N.
    function automatic logic [RW-1:0] reduce(
        input logic [RW-1:0]    acc,
        input logic [WIDTH-1:0] n
    );
        logic [RW-1:0] n_ext;
        logic [RW-1:0] two_n;
        n_ext = {2'b00, n};
        two_n = {1'b0, n, 1'b0};
        if (acc >= two_n) begin
            return acc - two_n;
        end else if (acc >= n_ext) begin
            return acc - n_ext;
        end else begin
            return acc;
        end
    endfunction

    logic [WIDTH-1:0] a_r, b_r, n_r;
    logic [RW-1:0]    acc_r;
    logic [CW-1:0]    cnt_r;
    logic             err_r;
    logic [WIDTH-1:0] result_r;
    logic             result_valid_r;

    logic [WIDTH-1:0] a_nxt_s, b_nxt_s, n_nxt_s;
    logic [RW-1:0]    acc_nxt_s;
    logic [CW-1:0]    cnt_nxt_s;
    logic             err_nxt_s;
    logic [WIDTH-1:0] result_nxt_s;
    logic             result_valid_nxt_s;
    logic [CW-1:0]    cnt_dec_s;
    logic             mul_bit_s;
    logic             cnt_zero_s;
    logic             load_err_s;

    assign cnt_zero_s = (cnt_r == CNT_ZERO);
    assign cnt_dec_s  = cnt_r - CNT_ONE;
    // Multiplier bit B_r[cnt-1], selected by mask to keep index widths matched.
    assign mul_bit_s  = |(b_r & ({{(WIDTH-1){1'b0}}, 1'b1} << cnt_dec_s));
    assign load_err_s = operands_illegal(operand_a, operand_b, modulus);

    // Next-state of operand, accumulator, counter and error registers (initialize > multiply > modulo).
    always_comb begin
        a_nxt_s   = a_r;
        b_nxt_s   = b_r;
        n_nxt_s   = n_r;
        acc_nxt_s = acc_r;
        cnt_nxt_s = cnt_r;
        err_nxt_s = err_r;
        if (initialize) begin
            a_nxt_s   = operand_a;
            b_nxt_s   = operand_b;
            n_nxt_s   = modulus;
            acc_nxt_s = {RW{1'b0}};
            err_nxt_s = load_err_s;
            cnt_nxt_s = load_err_s ? CNT_ZERO : CNT_FULL;
        end else if (en_multiply) begin
            if (!cnt_zero_s) begin
                acc_nxt_s = shift_add(acc_r, a_r, mul_bit_s);
                cnt_nxt_s = cnt_dec_s;
            end else begin
                acc_nxt_s = acc_r;
                cnt_nxt_s = cnt_r;
            end
        end else if (en_modulo) begin
            acc_nxt_s = reduce(acc_r, n_r);
        end else begin
            acc_nxt_s = acc_r;
        end
    end

    // Next-state of the result registers: cleared validity on load, capture on done once all bits are consumed.
    always_comb begin
        result_nxt_s       = result_r;
        result_valid_nxt_s = result_valid_r;
        if (initialize) begin
            result_valid_nxt_s = 1'b0;
        end else if (done && cnt_zero_s) begin
            result_nxt_s       = err_r ? {WIDTH{1'b0}} : acc_r[WIDTH-1:0];
            result_valid_nxt_s = 1'b1;
        end else begin
            result_valid_nxt_s = result_valid_r;
        end
    end

    // Datapath state registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r   <= {WIDTH{1'b0}};
            b_r   <= {WIDTH{1'b0}};
            n_r   <= {WIDTH{1'b0}};
            acc_r <= {RW{1'b0}};
            cnt_r <= CNT_ZERO;
            err_r <= 1'b0;
        end else begin
            a_r   <= a_nxt_s;
            b_r   <= b_nxt_s;
            n_r   <= n_nxt_s;
            acc_r <= acc_nxt_s;
            cnt_r <= cnt_nxt_s;
            err_r <= err_nxt_s;
        end
    end

    // Result output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_r       <= {WIDTH{1'b0}};
            result_valid_r <= 1'b0;
        end else begin
            result_r       <= result_nxt_s;
            result_valid_r <= result_valid_nxt_s;
        end
    end

    assign is_multiplication_done = cnt_zero_s;
    assign result                 = result_r;
    assign result_valid           = result_valid_r;
    assign error                  = err_r;

endmodule
